// File: rtl/pe_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pe_seq_pkg
//  Purpose : Shared state encoding and width helper for the PE layer
//            sequencer and its coordinate counters.
//  Revision: 1.0  initial release
// ============================================================================
package pe_seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_seq_coord_cnt.sv
`default_nettype none
// ============================================================================
//  Module  : pe_seq_coord_cnt
//  Purpose : Raster-order row/column counter. Column advances on inc and
//            wraps into the next row; the last position wraps to (0,0).
//  Revision: 1.0  initial release
// ============================================================================
module pe_seq_coord_cnt
  import pe_seq_pkg::*;
#(
  parameter int H = 1,
  parameter int W = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       inc,
  output logic [clog2_min1(H)-1:0]   row,
  output logic [clog2_min1(W)-1:0]   col,
  output logic                       last
);

  localparam int RW = clog2_min1(H);
  localparam int CW = clog2_min1(W);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  // Next position: clear wins over increment; wrap column then row.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (inc) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule
`default_nettype wire

// File: rtl/pe_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : pe_layer_sequencer
//  Purpose : Walks every output pixel of one conv layer in raster order,
//            hands windows to a single PE with a bounded number in flight,
//            tags returning results with their coordinates and pulses done
//            once the last result is back.
//  Revision: 1.0  initial release
// ============================================================================
module pe_layer_sequencer
  import pe_seq_pkg::*;
#(
  parameter int OUT_HEIGHT   = 32,
  parameter int OUT_WIDTH    = 64,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                abort,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  input  logic                                win_valid,
  output logic                                win_ready,
  output logic                                pe_i_valid,
  input  logic                                pe_ready,
  input  logic                                pe_ack,
  input  logic                                pe_o_valid,
  output logic [clog2_min1(OUT_HEIGHT)-1:0]   iss_row,
  output logic [clog2_min1(OUT_WIDTH)-1:0]    iss_col,
  output logic [clog2_min1(OUT_HEIGHT)-1:0]   res_row,
  output logic [clog2_min1(OUT_WIDTH)-1:0]    res_col
);

  localparam int TOTAL = OUT_HEIGHT * OUT_WIDTH;
  localparam int CNTW  = clog2_min1(TOTAL + 1);
  localparam int IFW   = clog2_min1(MAX_INFLIGHT + 1);
  localparam logic [CNTW-1:0] TOTAL_C = CNTW'(TOTAL);
  localparam logic [IFW-1:0]  MAX_C   = IFW'(MAX_INFLIGHT);

  logic [1:0]      state_q, state_d;
  logic [CNTW-1:0] iss_cnt_q, iss_cnt_d;
  logic [CNTW-1:0] res_cnt_q, res_cnt_d;
  logic [IFW-1:0]  inflight_q, inflight_d;
  logic            pe_i_valid_q, pe_i_valid_d;
  logic            err_q, err_d;

  logic start_acc;   // start honoured this cycle
  logic ack_acc;     // window handed to the PE this cycle
  logic res_act;     // states in which results are counted
  logic res_fire;    // a legitimate result is counted this cycle
  logic stray;       // result with nothing outstanding
  logic clr;         // return all counters to zero
  logic iss_last;
  logic res_last;

  assign start_acc = (state_q == ST_IDLE) && start && !abort;
  assign ack_acc   = pe_i_valid_q && pe_ack;
  assign res_act   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign res_fire  = pe_o_valid && res_act && (inflight_q != '0) && (res_cnt_q != TOTAL_C);
  assign stray     = pe_o_valid && ((state_q == ST_IDLE) || (inflight_q == '0));
  // Leaving DONE also zeroes the counters so IDLE always starts clean.
  assign clr       = abort || start_acc || (state_q == ST_DONE);

  // Next state; abort overrides every transition. A final result seen in
  // RUN goes straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_acc) state_d = ST_RUN;
      ST_RUN: begin
        if (res_fire && res_last)     state_d = ST_DONE;
        else if (ack_acc && iss_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (res_fire && res_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Issue/result/in-flight counters; simultaneous ack and result cancel out.
  always_comb begin
    iss_cnt_d  = iss_cnt_q;
    res_cnt_d  = res_cnt_q;
    inflight_d = inflight_q;
    if (clr) begin
      iss_cnt_d  = '0;
      res_cnt_d  = '0;
      inflight_d = '0;
    end else begin
      iss_cnt_d = iss_cnt_q + CNTW'(ack_acc);
      res_cnt_d = res_cnt_q + CNTW'(res_fire);
      case ({ack_acc, res_fire})
        2'b10:   inflight_d = inflight_q + 1'b1;
        2'b01:   inflight_d = inflight_q - 1'b1;
        default: inflight_d = inflight_q;
      endcase
    end
  end

  // Offer a window next cycle: hold an unacked offer, otherwise qualify a
  // new one against the post-update in-flight and issue counts so the cap
  // is never exceeded even with back-to-back acks.
  always_comb begin
    pe_i_valid_d = 1'b0;
    if (state_d == ST_RUN) begin
      pe_i_valid_d = (pe_i_valid_q && !pe_ack) ||
                     (win_valid && pe_ready && (inflight_d < MAX_C) &&
                      (iss_cnt_d != TOTAL_C));
    end
  end

  // Sticky error flag; an accepted start begins a clean layer.
  always_comb begin
    err_d = err_q;
    if (start_acc)  err_d = 1'b0;
    else if (stray) err_d = 1'b1;
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      iss_cnt_q    <= '0;
      res_cnt_q    <= '0;
      inflight_q   <= '0;
      pe_i_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      iss_cnt_q    <= iss_cnt_d;
      res_cnt_q    <= res_cnt_d;
      inflight_q   <= inflight_d;
      pe_i_valid_q <= pe_i_valid_d;
      err_q        <= err_d;
    end
  end

  pe_seq_coord_cnt #(.H(OUT_HEIGHT), .W(OUT_WIDTH)) u_iss_coord (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .inc  (ack_acc),
    .row  (iss_row),
    .col  (iss_col),
    .last (iss_last)
  );

  pe_seq_coord_cnt #(.H(OUT_HEIGHT), .W(OUT_WIDTH)) u_res_coord (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .inc  (res_fire),
    .row  (res_row),
    .col  (res_col),
    .last (res_last)
  );

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign pe_i_valid = pe_i_valid_q;
  assign win_ready  = ack_acc;

endmodule
`default_nettype wire

// File: tb/tb_pe_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_pe_layer_sequencer
//  Purpose : Directed bench: a 2x3 layer with a cap of two windows in
//            flight, plus a 1x1 layer on a second instance.
//  Revision: 1.0  initial release
// ============================================================================
module tb_pe_layer_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 2x3 instance
  logic start = 0, abort = 0, win_valid = 1, pe_ready = 1, pe_ack = 0, pe_o_valid = 0;
  logic busy, done, err, win_ready, pe_i_valid;
  logic [0:0] iss_row, res_row;
  logic [1:0] iss_col, res_col;

  pe_layer_sequencer #(.OUT_HEIGHT(2), .OUT_WIDTH(3), .MAX_INFLIGHT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .err(err), .win_valid(win_valid), .win_ready(win_ready), .pe_i_valid(pe_i_valid),
    .pe_ready(pe_ready), .pe_ack(pe_ack), .pe_o_valid(pe_o_valid),
    .iss_row(iss_row), .iss_col(iss_col), .res_row(res_row), .res_col(res_col)
  );

  // 1x1 instance
  logic b_start = 0, b_abort = 0, b_win_valid = 1, b_pe_ready = 1, b_pe_ack = 0, b_pe_o_valid = 0;
  logic b_busy, b_done, b_err, b_win_ready, b_pe_i_valid;
  logic [0:0] b_iss_row, b_iss_col, b_res_row, b_res_col;

  pe_layer_sequencer #(.OUT_HEIGHT(1), .OUT_WIDTH(1), .MAX_INFLIGHT(2)) dut1 (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .busy(b_busy), .done(b_done),
    .err(b_err), .win_valid(b_win_valid), .win_ready(b_win_ready), .pe_i_valid(b_pe_i_valid),
    .pe_ready(b_pe_ready), .pe_ack(b_pe_ack), .pe_o_valid(b_pe_o_valid),
    .iss_row(b_iss_row), .iss_col(b_iss_col), .res_row(b_res_row), .res_col(b_res_col)
  );

  typedef struct {
    int st, ack, ov;                          // inputs for the cycle
    int busy, done, err, piv, wr, ir, ic, rr, rc;  // expected outputs
  } vec_t;

  vec_t tbl [17];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   acks;
  logic a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, settle, then return.
  task automatic drv(input logic st, input logic ab, input logic ack, input logic ov);
    @(negedge clk);
    start = st; abort = ab; pe_ack = ack; pe_o_valid = ov;
    #1;
  endtask

  // PE acks whatever is offered in the same cycle.
  task automatic astep(input logic ov, output logic acked);
    @(negedge clk);
    start = 0; abort = 0; pe_o_valid = ov; pe_ack = pe_i_valid;
    #1;
    acked = win_ready;
  endtask

  initial begin
    // Same-cycle ack, results returned three cycles after each ack.
    //            st ack ov  busy done err piv wr ir ic rr rc
    tbl[0]  = '{1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0,   1, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0,   1, 0, 0, 1, 1, 0, 1, 0, 0};
    tbl[3]  = '{1, 0, 0,   1, 0, 0, 0, 0, 0, 2, 0, 0};  // start in RUN ignored
    tbl[4]  = '{0, 0, 1,   1, 0, 0, 0, 0, 0, 2, 0, 0};
    tbl[5]  = '{0, 1, 1,   1, 0, 0, 1, 1, 0, 2, 0, 1};
    tbl[6]  = '{0, 1, 0,   1, 0, 0, 1, 1, 1, 0, 0, 2};
    tbl[7]  = '{0, 0, 0,   1, 0, 0, 0, 0, 1, 1, 0, 2};
    tbl[8]  = '{0, 0, 1,   1, 0, 0, 0, 0, 1, 1, 0, 2};
    tbl[9]  = '{0, 1, 1,   1, 0, 0, 1, 1, 1, 1, 1, 0};
    tbl[10] = '{0, 1, 0,   1, 0, 0, 1, 1, 1, 2, 1, 1};
    tbl[11] = '{0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[12] = '{0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[13] = '{0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 1, 2};
    tbl[14] = '{1, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0};  // start in DONE ignored
    tbl[15] = '{0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[16] = '{0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0};

    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err",  err,  0);
    chk("reset piv",  pe_i_valid, 0);
    chk("reset wr",   win_ready, 0);
    chk("reset iss",  {iss_row, iss_col}, 0);
    chk("reset res",  {res_row, res_col}, 0);

    // Full 2x3 layer from the vector table.
    for (int i = 0; i < 17; i++) begin
      drv(tbl[i].st != 0, 1'b0, tbl[i].ack != 0, tbl[i].ov != 0);
      chk($sformatf("v%0d busy", i), busy, tbl[i].busy);
      chk($sformatf("v%0d done", i), done, tbl[i].done);
      chk($sformatf("v%0d err", i),  err,  tbl[i].err);
      chk($sformatf("v%0d piv", i),  pe_i_valid, tbl[i].piv);
      chk($sformatf("v%0d wr", i),   win_ready, tbl[i].wr);
      chk($sformatf("v%0d iss_row", i), iss_row, tbl[i].ir);
      chk($sformatf("v%0d iss_col", i), iss_col, tbl[i].ic);
      chk($sformatf("v%0d res_row", i), res_row, tbl[i].rr);
      chk($sformatf("v%0d res_col", i), res_col, tbl[i].rc);
    end

    // Results withheld: in-flight cap stops issue at two.
    drv(1, 0, 0, 0);
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      astep(1'b0, a);
      if (a) acks++;
    end
    chk("cap acks", acks, 2);
    chk("cap piv", pe_i_valid, 0);
    acks = 0;
    astep(1'b1, a);
    if (a) acks++;
    for (int k = 0; k < 6; k++) begin
      astep(1'b0, a);
      if (a) acks++;
    end
    chk("refill acks", acks, 1);
    drv(0, 1, 0, 0);
    drv(0, 0, 0, 0);
    chk("cap abort busy", busy, 0);

    // Simultaneous ack and result with one in flight, then abort in DRAIN.
    drv(1, 0, 0, 0);
    drv(0, 0, 1, 0);
    chk("sim piv0", pe_i_valid, 1);
    drv(0, 0, 1, 1);
    chk("sim piv1", pe_i_valid, 1);
    drv(0, 0, 1, 0);
    chk("sim iss", {iss_row, iss_col}, 3'b0_10);
    chk("sim res", {res_row, res_col}, 3'b0_01);
    chk("sim piv2", pe_i_valid, 1);
    drv(0, 0, 0, 0);
    chk("sim cap piv", pe_i_valid, 0);
    chk("sim iss2", {iss_row, iss_col}, 3'b1_00);
    for (int k = 0; k < 3; k++) begin
      drv(0, 0, 0, 1);
      drv(0, 0, 1, 0);
      chk($sformatf("drain piv%0d", k), pe_i_valid, 1);
    end
    drv(0, 0, 0, 0);
    chk("drain busy", busy, 1);
    chk("drain piv", pe_i_valid, 0);
    chk("drain iss", {iss_row, iss_col}, 0);
    chk("drain res", {res_row, res_col}, 3'b1_01);
    drv(0, 1, 0, 0);
    drv(0, 0, 0, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort res", {res_row, res_col}, 0);
    drv(0, 0, 0, 1);
    chk("stray pre err", err, 0);
    drv(0, 0, 0, 0);
    chk("stray err", err, 1);
    chk("stray done", done, 0);
    drv(1, 1, 0, 0);
    drv(0, 0, 0, 0);
    chk("abort>start busy", busy, 0);
    chk("abort>start err", err, 1);
    drv(1, 0, 0, 0);
    drv(0, 0, 0, 0);
    chk("restart err", err, 0);
    chk("restart busy", busy, 1);
    drv(0, 1, 0, 0);
    drv(0, 0, 0, 0);

    // Synchronous reset in the middle of RUN.
    drv(1, 0, 0, 0);
    drv(0, 0, 0, 1);
    drv(0, 0, 1, 0);
    chk("run err", err, 1);
    chk("run piv", pe_i_valid, 1);
    drv(0, 0, 0, 0);
    chk("run iss_col", iss_col, 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err",  err,  0);
    chk("rst piv",  pe_i_valid, 0);
    chk("rst wr",   win_ready, 0);
    chk("rst iss",  {iss_row, iss_col}, 0);
    chk("rst res",  {res_row, res_col}, 0);

    // 1x1 layer on the second instance.
    @(negedge clk); b_start = 1;
    @(negedge clk); b_start = 0; b_pe_ack = 1; #1;
    chk("1x1 busy", b_busy, 1);
    chk("1x1 piv",  b_pe_i_valid, 1);
    chk("1x1 iss",  {b_iss_row, b_iss_col}, 0);
    @(negedge clk); b_pe_ack = 0; b_pe_o_valid = 1; #1;
    chk("1x1 drain piv", b_pe_i_valid, 0);
    chk("1x1 drain done", b_done, 0);
    chk("1x1 drain iss", {b_iss_row, b_iss_col}, 0);
    chk("1x1 res", {b_res_row, b_res_col}, 0);
    @(negedge clk); b_pe_o_valid = 0; #1;
    chk("1x1 done", b_done, 1);
    chk("1x1 err", b_err, 0);
    @(negedge clk); #1;
    chk("1x1 idle busy", b_busy, 0);
    chk("1x1 idle done", b_done, 0);
    chk("1x1 idle res", {b_res_row, b_res_col}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_layer_sequencer.md
# pe_layer_sequencer

Sequences one conv layer through a single `pe` instance: after a start pulse it walks every output pixel position in raster order and passes windows from the window buffer to the PE over the `i_valid`/`pe_ready`/`pe_ack` handshake. It caps the number of windows in flight, counts returned PE results, tags each result with its row and column, and signals layer completion. It sits between the line/window buffer and the PE, under the top-level layer scheduler.

## Interface
- `OUT_HEIGHT`, 32: output rows per layer (≥1).
- `OUT_WIDTH`, 64: output columns per layer (≥1).
- `MAX_INFLIGHT`, 2: maximum windows acked by the PE but whose results have not yet returned (≥1).
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: begin a layer; honoured only in IDLE.
- `abort`  in  1: return to IDLE next cycle from any state.
- `busy`  out  1: high in RUN, DRAIN and DONE.
- `done`  out  1: one-cycle pulse when the last result has returned.
- `err`  out  1: sticky; set when `pe_o_valid` arrives while the in-flight count is 0; cleared by an accepted `start` or by `rst`.
- `win_valid`  in  1: the window buffer has a window ready.
- `win_ready`  out  1: the window is consumed this cycle; equals `pe_i_valid & pe_ack`.
- `pe_i_valid`  out  1: drives the PE's `i_valid`.
- `pe_ready`  in  1: PE can accept a window.
- `pe_ack`  in  1: PE latched the window this cycle.
- `pe_o_valid`  in  1: PE result valid (one per window, in order).
- `iss_row`  out  clog2(OUT_HEIGHT): row of the window being offered.
- `iss_col`  out  clog2(OUT_WIDTH): column of the window being offered.
- `res_row`  out  clog2(OUT_HEIGHT): row of the result on `pe_o_valid`.
- `res_col`  out  clog2(OUT_WIDTH): column of the result on `pe_o_valid`.
- Widths of 1 are used where clog2 yields 0.

## Operation
- State machine IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: all counters are zero.
  - `start` → RUN. Clears the issue count, result count, in-flight count, all coordinates, and `err`.
- RUN:
  - `pe_i_valid = win_valid & pe_ready & (inflight < MAX_INFLIGHT)`.
  - Once `pe_i_valid` is raised, it is held (sticky) until `pe_ack`, regardless of later `pe_ready` changes.
  - On `pe_ack`: issue count +1, in-flight +1, issue coordinate advances.
  - Ack of window `OUT_HEIGHT*OUT_WIDTH-1` → DRAIN. No further `pe_i_valid`.
- Results, in RUN and DRAIN: on `pe_o_valid`, result count +1, in-flight −1, result coordinate advances.
- Simultaneous `pe_ack` and `pe_o_valid`: in-flight count unchanged; both counters advance.
- DRAIN:
  - Result count reaching total → DONE. If the final result arrives while still in RUN, go directly to DONE.
- DONE: `done=1` for exactly one cycle, then IDLE. `start` is ignored in DONE.
- Coordinate advance (issue and result counters behave identically):
  - `col` +1.
  - At `OUT_WIDTH-1`, `col` wraps to 0 and `row` +1.
  - At the last row/col, both wrap to 0.
- `abort`, any state: next cycle IDLE, counters cleared, `pe_i_valid=0`, no `done`. `abort` has priority over `start`.
- `pe_o_valid` in IDLE, or with in-flight = 0: sets `err`; counters unchanged, no underflow.
- Counter widths:
  - Issue/result counters: clog2(OUT_HEIGHT*OUT_WIDTH+1).
  - In-flight counter: clog2(MAX_INFLIGHT+1).
  - All unsigned, no saturation needed.

## Timing
- Reset values: state IDLE; `busy=0`, `done=0`, `err=0`, `pe_i_valid=0`, `win_ready=0`, all coordinates 0.
- `start` sampled at edge N → `busy=1` and RUN from cycle N+1. `pe_i_valid` may be high in N+1.
- `pe_i_valid` is a registered output. It rises the cycle after its enable condition is sampled.
- `pe_ack` sampled at edge M → `pe_i_valid` is low in cycle M+1 unless the next window qualifies. No dead cycle is required; back-to-back issue is allowed.
- `iss_*` and `res_*` are registers. They are valid during the cycle of `pe_i_valid` / `pe_o_valid` respectively and update after the accepting edge.
- Final `pe_o_valid` at edge K → `done=1` in cycle K+1 → `busy=0` in cycle K+2.

## Structure
- Shared package `pe_seq_pkg`:
  - State encoding localparams (IDLE=0, RUN=1, DRAIN=2, DONE=3).
  - A clog2-with-minimum-1 width function.
- Sub-module `pe_seq_coord_cnt` (params H, W; ports `clk`, `rst`, `clr`, `inc`, `row`, `col`, `last`). Instantiated twice, for the issue and result coordinates.

## Test plan
- H=2, W=3, MAX=2, `win_valid=1`, `pe_ready=1`, PE acks the same cycle and returns results 3 cycles later:
  - Expect 6 acks with `iss` (0,0)(0,1)(0,2)(1,0)(1,1)(1,2), and 6 results with matching `res` tags.
  - Expect `done` one cycle after the 6th `pe_o_valid`, and `busy` low the cycle after that.
- Same configuration, PE withholds results: expect exactly 2 acks, then `pe_i_valid` stays low. Returning 1 result → exactly one further issue.
- `pe_ack` and `pe_o_valid` in the same cycle with in-flight = 1 → in-flight stays 1; issue and result counts both increment.
- `abort` in DRAIN with 2 in flight → IDLE next cycle, no `done`. A following stray `pe_o_valid` → `err=1`. A new `start` → `err=0`.
- `start` asserted in DONE and in RUN → ignored; a single `done` pulse per layer.
- `rst` high mid-RUN for one cycle → all outputs at reset values on the next cycle.
- H=1, W=1 → one issue, one result, `done`; coordinates stay (0,0).
